// File: rtl/hog_pixel_source.sv
// Synthetic raster-frame generator driving the HOG pixel_in / pixel_valid / pixel_ready handshake.
// state  | meaning
// IDLE   | waiting for start, nothing presented
// STREAM | presenting pixels of the current frame
// GAP    | idle cycles between frames in continuous mode
module hog_pixel_source #(
  parameter int DATA_WIDTH    = 8,
  parameter int IMAGE_WIDTH   = 640,
  parameter int IMAGE_HEIGHT  = 480,
  parameter int GAP_CYCLES    = 16,
  parameter int CHECKER_SHIFT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [1:0]            pattern_sel,
  input  logic [DATA_WIDTH-1:0] const_pixel,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count
);

  localparam int COL_W = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
  localparam int ROW_W = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int GAP_W = (GAP_CYCLES   > 1) ? $clog2(GAP_CYCLES)   : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  // Masks picking the counter bit that toggles every checker square (zero if out of range).
  localparam logic [COL_W-1:0] COL_CHK  = COL_W'(1) << CHECKER_SHIFT;
  localparam logic [ROW_W-1:0] ROW_CHK  = ROW_W'(1) << CHECKER_SHIFT;
  localparam bit               NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

  state_t                  state;
  logic [COL_W-1:0]        col, nxt_col;
  logic [ROW_W-1:0]        row, nxt_row;
  logic [GAP_W-1:0]        gap_cnt;
  logic [1:0]              pat_q;
  logic [DATA_WIDTH-1:0]   const_q;
  logic                    xfer, last_col, last_row, eof, launch;

  function automatic logic [DATA_WIDTH-1:0] pixel_at(
    input logic [1:0]            pat,
    input logic [DATA_WIDTH-1:0] cval,
    input logic [COL_W-1:0]      c,
    input logic [ROW_W-1:0]      r
  );
    logic [DATA_WIDTH-1:0] v;
    case (pat)
      2'd0:    v = cval;
      2'd1:    v = DATA_WIDTH'(c);
      2'd2:    v = DATA_WIDTH'(r);
      default: v = ((|(c & COL_CHK)) ^ (|(r & ROW_CHK))) ? '1 : '0;
    endcase
    return v;
  endfunction

  always_comb begin
    xfer     = pixel_valid & pixel_ready;
    last_col = (col == COL_LAST);
    last_row = (row == ROW_LAST);
    eof      = (state == STREAM) & xfer & last_col & last_row;
    nxt_col  = last_col ? '0 : col + 1'b1;
    nxt_row  = last_col ? row + 1'b1 : row;
    // A new frame starts from IDLE, back-to-back when there is no gap, or at the end of GAP.
    launch   = ((state == IDLE) & start)
             | (eof & continuous & NO_GAP)
             | ((state == GAP) & (gap_cnt == '0) & continuous);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      gap_cnt     <= '0;
      pat_q       <= '0;
      const_q     <= '0;
      pixel_out   <= '0;
      pixel_valid <= 1'b0;
      sof         <= 1'b0;
      eol         <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (launch) begin
        state       <= STREAM;
        col         <= '0;
        row         <= '0;
        pat_q       <= pattern_sel;
        const_q     <= const_pixel;
        pixel_out   <= pixel_at(pattern_sel, const_pixel, '0, '0);
        pixel_valid <= 1'b1;
        sof         <= 1'b1;
        eol         <= (COL_LAST == '0);
        busy        <= 1'b1;
      end else begin
        case (state)
          STREAM: begin
            if (xfer) begin
              if (last_col && last_row) begin
                col         <= '0;
                row         <= '0;
                pixel_out   <= '0;
                pixel_valid <= 1'b0;
                sof         <= 1'b0;
                eol         <= 1'b0;
                if (continuous) begin
                  state   <= GAP;
                  gap_cnt <= GAP_LOAD;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                col       <= nxt_col;
                row       <= nxt_row;
                pixel_out <= pixel_at(pat_q, const_q, nxt_col, nxt_row);
                sof       <= 1'b0;
                eol       <= (nxt_col == COL_LAST);
              end
            end
          end
          GAP: begin
            if (gap_cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          default: ;
        endcase
      end
      if (eof) begin
        frame_done  <= 1'b1;
        frame_count <= frame_count + 16'd1;
      end
    end
  end

endmodule

// File: doc/hog_pixel_source.md
Name: hog_pixel_source

Overview:
- Transmitter end of the HOG pixel input handshake (pixel_in / pixel_valid / pixel_ready).
- Generates complete raster frames of IMAGE_WIDTH x IMAGE_HEIGHT synthetic pixels and streams them into the HOG top.
- Replaces the current switch/key stimulus on the DE1-SoC so the pipeline can be exercised at full rate with known, repeatable content.
- Sits between board controls (KEY/SW) and the HOG top, in the same clk domain as the HOG top.

Parameters:
- DATA_WIDTH, 8, pixel bit width.
- IMAGE_WIDTH, 640, pixels per line.
- IMAGE_HEIGHT, 480, lines per frame.
- GAP_CYCLES, 16, idle cycles between frames in continuous mode (0 allowed).
- CHECKER_SHIFT, 3, log2 of checkerboard square size.

Ports:
- clk  in  1  system clock; every register is clocked on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin streaming; sampled only in IDLE.
- continuous  in  1  1 = repeat frames until cleared; sampled at each end of frame.
- pattern_sel  in  2  0 const, 1 horizontal ramp, 2 vertical ramp, 3 checkerboard.
- const_pixel  in  DATA_WIDTH  value used by pattern 0.
- pixel_out  out  DATA_WIDTH  pixel data, connects to the HOG pixel_in.
- pixel_valid  out  1  pixel_out holds a valid pixel.
- pixel_ready  in  1  sink accepts the current pixel.
- sof  out  1  qualifies pixel (0,0) of a frame; meaningful only while pixel_valid=1.
- eol  out  1  qualifies the last pixel of a line; meaningful only while pixel_valid=1.
- busy  out  1  1 in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- frame_count  out  16  number of completed frames; wraps from 0xFFFF to 0.

Behaviour:
- Reset:
  - All outputs are 0; state = IDLE.
  - col, row and gap counters are 0.
  - Reset asserted mid-frame aborts the frame; outputs are 0 on the cycle after rst is sampled high.
- States: IDLE, STREAM, GAP.
- IDLE:
  - start=1 → STREAM on the next edge.
  - pixel_valid=1 with pixel (0,0) and sof=1 on that same next cycle (1-cycle latency).
  - pattern_sel and const_pixel are latched on this transition and held for the whole frame.
- STREAM:
  - pixel_valid stays 1 throughout. Transfer occurs on a cycle with pixel_valid & pixel_ready.
  - While pixel_ready=0, pixel_out, sof and eol remain stable (no-drop, no-change rule).
  - Raster order: col increments per transfer; at col=IMAGE_WIDTH-1, col wraps to 0 and row increments.
  - eol=1 when col=IMAGE_WIDTH-1.
  - Full rate: back-to-back transfers at 1 pixel/clk when ready is held high.
- Pixel value:
  - Pattern 0: const_pixel.
  - Pattern 1: col mod 2^DATA_WIDTH.
  - Pattern 2: row mod 2^DATA_WIDTH.
  - Pattern 3: all-ones if ((row>>CHECKER_SHIFT) XOR (col>>CHECKER_SHIFT)) bit0 = 1, else 0.
  - pixel_out is registered and computed from the counters of the pixel being presented.
- End of frame (transfer at col=W-1, row=H-1):
  - Next cycle: frame_done=1 for exactly one cycle; frame_count increments; pixel_valid=0.
  - If continuous=1 at that transfer edge: → GAP when GAP_CYCLES>0; → STREAM directly when GAP_CYCLES=0, in which case pixel_valid stays 1 and the next pixel is (0,0) with sof=1, patterns re-latched.
  - Otherwise → IDLE.
- GAP:
  - pixel_valid=0; count GAP_CYCLES cycles, then → STREAM with pixel (0,0) and patterns re-latched.
  - If continuous drops to 0 during GAP, GAP still completes, then → IDLE instead of STREAM.
- Other rules:
  - start is ignored in STREAM and GAP; start and rst high together: rst wins.
  - pattern_sel changes mid-frame have no effect until the next frame.
  - Counter widths are clog2(IMAGE_WIDTH) and clog2(IMAGE_HEIGHT).

Test Plan:
- W=4, H=3, pattern 1, ready held 1, single start → 12 transfers on consecutive cycles, values 0,1,2,3 per line; sof on pixel 0; eol on pixels 3,7,11; frame_done 1 cycle after pixel 11; frame_count=1; busy falls.
- Same config, ready toggled 1,0,0,1 pseudo-randomly → still exactly 12 transfers, in order; pixel_out/sof/eol never change while ready=0.
- Pattern 3 at default 640x480, CHECKER_SHIFT=3 → pixel(7,0)=0x00, pixel(8,0)=0xFF, pixel(8,8)=0x00; exactly 307200 transfers.
- continuous=1, GAP_CYCLES=16, W=4, H=3 → pixel_valid low for exactly 16 cycles between frames; clear continuous during the third frame → stops after that frame with frame_count=3.
- rst asserted after 5 transfers → next cycle all outputs 0; a new start restarts at (0,0) with sof=1; frame_count=0.
- frame_count preloaded near wrap via long continuous run with GAP_CYCLES=0, W=H=1 → 0xFFFF→0x0000 wrap; pixel_valid stays continuously 1 with sof on every pixel.
